// File: rtl/wb_pkg.sv
// Shared definitions for the writeback retire buffer.
// Entry layout, zip width and pointer sizing helpers.
package wb_pkg;

    localparam int XLEN_D    = 32;
    localparam int RADDR_W_D = 5;
    localparam int ECODE_W_D = 6;

    // Width of the {we, waddr, wdata} bundle.
    function automatic int zip_w(input int xlen, input int raddr_w);
        return 1 + raddr_w + xlen;
    endfunction

    localparam int ZIP_W = zip_w(XLEN_D, RADDR_W_D);

    // Bits needed to index DEPTH entries.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Entry layout at the default widths.
    typedef struct packed {
        logic [XLEN_D-1:0]    pc;
        logic                 we;
        logic [RADDR_W_D-1:0] waddr;
        logic [XLEN_D-1:0]    wdata;
        logic                 ex;
        logic [ECODE_W_D-1:0] ecode;
    } wb_entry_t;

endpackage

// File: rtl/wb_pend_decode.sv
// Pending-write mask for ID hazard detection.
// One-hot decode per entry, OR-reduced; r0 never pends.
module wb_pend_decode
    import wb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int RADDR_W = 5
) (
    input  logic [DEPTH-1:0]           i_wr,
    input  logic [DEPTH*RADDR_W-1:0]   i_waddr,
    output logic [(1<<RADDR_W)-1:0]    o_mask
);

    localparam int NREG = 1 << RADDR_W;

    logic [NREG-1:0] w_onehot [DEPTH];

    // Per-entry one-hot of the destination, zero when the entry will not write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_onehot[i] = '0;
            if (i_wr[i]) begin
                w_onehot[i][i_waddr[i*RADDR_W +: RADDR_W]] = 1'b1;
            end
        end
    end

    // Merge all entries and drop r0.
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_mask = o_mask | w_onehot[i];
        end
        o_mask[0] = 1'b0;
    end

endmodule

// File: rtl/wb_retire_buf.sv
// Writeback stage as an in-order retire buffer between MEM and the regfile.
// Handles regfile port backpressure, exception flush and pending-write mask.
module wb_retire_buf
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2,
    parameter int ECODE_W = ECODE_W_D
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms2ws_valid,
    output logic                       ws_allowin,
    input  logic [XLEN-1:0]            ms_pc,
    input  logic [XLEN+RADDR_W:0]      ms_rf_zip,
    input  logic                       ms_ex,
    input  logic [ECODE_W-1:0]         ms_ecode,
    input  logic                       rf_port_ready,
    output logic [XLEN+RADDR_W:0]      ws_rf_zip,
    output logic [(1<<RADDR_W)-1:0]    ws_pend_mask,
    output logic                       ws_flush,
    output logic [XLEN-1:0]            ws_ex_pc,
    output logic [ECODE_W-1:0]         ws_ecode,
    output logic [ptr_w(DEPTH):0]      ws_count,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [XLEN-1:0]    wdata;
        logic               ex;
        logic [ECODE_W-1:0] ecode;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    entry_t                   w_head;
    entry_t                   w_in;
    logic                     w_empty;
    logic                     w_retire;
    logic                     w_flush;
    logic                     w_push;
    logic                     w_wr_rf;
    logic [DEPTH-1:0]         w_pend_wr;
    logic [DEPTH*RADDR_W-1:0] w_pend_addr;

    assign w_head  = r_mem[r_head];
    assign w_empty = (r_count == '0);

    // A writer head without an exception waits for the shared port.
    assign w_retire = ~w_empty
                    & (w_head.ex | ~w_head.we | rf_port_ready);
    assign w_flush  = w_retire & w_head.ex;
    assign w_wr_rf  = w_retire & w_head.we & ~w_head.ex;

    assign ws_allowin = (r_count < FULL) | w_retire;
    assign w_push     = ms2ws_valid & ws_allowin & ~w_flush;

    assign w_in.pc    = ms_pc;
    assign w_in.we    = ms_rf_zip[XLEN+RADDR_W];
    assign w_in.waddr = ms_rf_zip[XLEN +: RADDR_W];
    assign w_in.wdata = ms_rf_zip[XLEN-1:0];
    assign w_in.ex    = ms_ex;
    assign w_in.ecode = ms_ecode;

    // Pointer and occupancy update; a flush discards everything younger.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_retire);
        end
    end

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in;
        end
    end

    // Flag entries that are occupied and will write the regfile.
    always_comb begin
        logic [PW-1:0] off;
        w_pend_wr   = '0;
        w_pend_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - r_head;
            w_pend_wr[i] = ({1'b0, off} < r_count)
                         & r_mem[i].we & ~r_mem[i].ex;
            w_pend_addr[i*RADDR_W +: RADDR_W] = r_mem[i].waddr;
        end
    end

    wb_pend_decode #(
        .DEPTH   (DEPTH),
        .RADDR_W (RADDR_W)
    ) u_pend (
        .i_wr    (w_pend_wr),
        .i_waddr (w_pend_addr),
        .o_mask  (ws_pend_mask)
    );

    assign ws_rf_zip = {w_wr_rf, w_head.waddr, w_head.wdata};
    assign ws_flush  = w_flush;
    assign ws_ex_pc  = w_head.pc;
    assign ws_ecode  = w_head.ecode;
    assign ws_count  = r_count;

    assign debug_wb_pc       = 32'(w_head.pc);
    assign debug_wb_rf_we    = {4{w_wr_rf}};
    assign debug_wb_rf_wnum  = 5'(w_head.waddr);
    assign debug_wb_rf_wdata = 32'(w_head.wdata);

endmodule

// File: tb/tb_wb_retire_buf.sv
// Self-checking bench for wb_retire_buf.
// Directed scenarios then random traffic against a queue model.
module tb_wb_retire_buf;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int DEPTH   = 2;
    localparam int ECODE_W = 6;
    localparam int ZW      = 1 + RADDR_W + XLEN;

    logic              clk = 1'b0;
    logic              resetn;
    logic              ms2ws_valid;
    logic              ws_allowin;
    logic [XLEN-1:0]   ms_pc;
    logic [ZW-1:0]     ms_rf_zip;
    logic              ms_ex;
    logic [ECODE_W-1:0] ms_ecode;
    logic              rf_port_ready;
    logic [ZW-1:0]     ws_rf_zip;
    logic [31:0]       ws_pend_mask;
    logic              ws_flush;
    logic [XLEN-1:0]   ws_ex_pc;
    logic [ECODE_W-1:0] ws_ecode;
    logic [1:0]        ws_count;
    logic [31:0]       debug_wb_pc;
    logic [3:0]        debug_wb_rf_we;
    logic [4:0]        debug_wb_rf_wnum;
    logic [31:0]       debug_wb_rf_wdata;

    wb_retire_buf #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH),
        .ECODE_W (ECODE_W)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms2ws_valid       (ms2ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_rf_zip         (ms_rf_zip),
        .ms_ex             (ms_ex),
        .ms_ecode          (ms_ecode),
        .rf_port_ready     (rf_port_ready),
        .ws_rf_zip         (ws_rf_zip),
        .ws_pend_mask      (ws_pend_mask),
        .ws_flush          (ws_flush),
        .ws_ex_pc          (ws_ex_pc),
        .ws_ecode          (ws_ecode),
        .ws_count          (ws_count),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ecode;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input bit ex, input logic [5:0] ec);
        ms2ws_valid = v;
        ms_pc       = pc;
        ms_rf_zip   = {we, wa, wd};
        ms_ex       = ex;
        ms_ecode    = ec;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 5'd0, 32'h0, 0, 6'h0);
    endtask

    function automatic bit m_retire();
        if (q.size() == 0) return 0;
        return q[0].ex || !q[0].we || rf_port_ready;
    endfunction

    // Compare every output against what the queue model implies.
    task automatic check_model();
        bit          ret;
        bit          wr;
        logic [31:0] m;
        ret = m_retire();
        wr  = ret && q[0].we && !q[0].ex;
        m   = 32'h0;
        foreach (q[i]) begin
            if (q[i].we && !q[i].ex) m[q[i].waddr] = 1'b1;
        end
        m[0] = 1'b0;
        chk("count", ws_count, q.size());
        chk("allowin", ws_allowin, (q.size() < DEPTH) || ret);
        chk("flush", ws_flush, ret && q[0].ex);
        chk("pend_mask", ws_pend_mask, m);
        chk("rf_we", ws_rf_zip[ZW-1], wr);
        chk("dbg_we", debug_wb_rf_we, {4{wr}});
        if (q.size() != 0) begin
            chk("rf_zip", ws_rf_zip, {wr, q[0].waddr, q[0].wdata});
            chk("dbg_pc", debug_wb_pc, q[0].pc);
            chk("dbg_wnum", debug_wb_rf_wnum, q[0].waddr);
            chk("dbg_wdata", debug_wb_rf_wdata, q[0].wdata);
            if (q[0].ex) begin
                chk("ex_pc", ws_ex_pc, q[0].pc);
                chk("ecode", ws_ecode, q[0].ecode);
            end
        end
    endtask

    task automatic update_model();
        bit   ret;
        bit   acc;
        ent_t e;
        if (!resetn) begin
            q.delete();
            return;
        end
        ret = m_retire();
        acc = (q.size() < DEPTH) || ret;
        if (ret && q[0].ex) begin
            q.delete();
            return;
        end
        if (ret) void'(q.pop_front());
        if (ms2ws_valid && acc) begin
            e.pc    = ms_pc;
            e.we    = ms_rf_zip[ZW-1];
            e.waddr = ms_rf_zip[XLEN +: RADDR_W];
            e.wdata = ms_rf_zip[XLEN-1:0];
            e.ex    = ms_ex;
            e.ecode = ms_ecode;
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        rf_port_ready = 1'b1;
        idle();
        cycle();
        cycle();
        chk("rst_count", ws_count, 0);
        chk("rst_flush", ws_flush, 0);
        chk("rst_mask", ws_pend_mask, 0);
        chk("rst_dbg_we", debug_wb_rf_we, 0);
        chk("rst_allowin", ws_allowin, 1);
        resetn = 1'b1;

        // Back-to-back flow, one cycle each.
        rf_port_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1c000000 + 32'(4*k), 1, 5'(k+1),
                  32'ha0 + 32'(k), 0, 6'h0);
            cycle();
            idle();
            #1;
            chk("b2b_dbg_we", debug_wb_rf_we, 4'hf);
            chk("b2b_pc", debug_wb_pc, 32'h1c000000 + 32'(4*k));
            chk("b2b_count", ws_count, 1);
            chk("b2b_allowin", ws_allowin, 1);
        end
        cycle();
        chk("b2b_drain", ws_count, 0);

        // Regfile port stall.
        rf_port_ready = 1'b0;
        drive(1, 32'h100, 1, 5'd4, 32'h44, 0, 6'h0);
        cycle();
        drive(1, 32'h104, 1, 5'd5, 32'h55, 0, 6'h0);
        cycle();
        idle();
        #1;
        chk("stall_count", ws_count, 2);
        chk("stall_allowin", ws_allowin, 0);
        chk("stall_mask", ws_pend_mask, 32'h30);
        rf_port_ready = 1'b1;
        #1;
        chk("stall_r4", ws_rf_zip, {1'b1, 5'd4, 32'h44});
        cycle();
        chk("stall_r5", ws_rf_zip, {1'b1, 5'd5, 32'h55});
        cycle();
        chk("stall_drain", ws_count, 0);

        // Full push/pop, then exception flush with a live incoming beat.
        rf_port_ready = 1'b0;
        drive(1, 32'h200, 1, 5'd3, 32'h33, 0, 6'h0);
        cycle();
        drive(1, 32'h204, 1, 5'd7, 32'h77, 1, 6'h0b);
        cycle();
        rf_port_ready = 1'b1;
        drive(1, 32'h208, 1, 5'd6, 32'h66, 0, 6'h0);
        #1;
        chk("full_allowin", ws_allowin, 1);
        cycle();
        chk("full_count", ws_count, 2);
        chk("full_order", debug_wb_pc, 32'h204);
        drive(1, 32'h20c, 1, 5'd9, 32'h99, 0, 6'h0);
        #1;
        chk("ex_flush", ws_flush, 1);
        chk("ex_pc_dir", ws_ex_pc, 32'h204);
        chk("ex_ecode_dir", ws_ecode, 6'h0b);
        chk("ex_no_write", ws_rf_zip[ZW-1], 0);
        cycle();
        idle();
        #1;
        chk("ex_count", ws_count, 0);
        chk("ex_flush_1cyc", ws_flush, 0);
        chk("ex_mask", ws_pend_mask, 0);

        // Non-writer bypasses a busy port; r0 never pends.
        rf_port_ready = 1'b0;
        drive(1, 32'h300, 0, 5'd8, 32'h88, 0, 6'h0);
        cycle();
        idle();
        #1;
        chk("nw_count", ws_count, 1);
        chk("nw_dbg_we", debug_wb_rf_we, 0);
        chk("nw_allowin", ws_allowin, 1);
        cycle();
        chk("nw_drain", ws_count, 0);
        drive(1, 32'h304, 1, 5'd0, 32'h1, 0, 6'h0);
        cycle();
        drive(1, 32'h308, 1, 5'd9, 32'h2, 0, 6'h0);
        cycle();
        idle();
        #1;
        chk("r0_mask", ws_pend_mask, 32'h200);
        chk("r0_count", ws_count, 2);

        // Reset while full.
        resetn = 1'b0;
        cycle();
        chk("mrst_count", ws_count, 0);
        chk("mrst_flush", ws_flush, 0);
        chk("mrst_mask", ws_pend_mask, 0);
        chk("mrst_dbg_we", debug_wb_rf_we, 0);
        chk("mrst_allowin", ws_allowin, 1);
        resetn = 1'b1;

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            rf_port_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
                  5'($urandom), $urandom, $urandom_range(0, 7) == 0,
                  6'($urandom));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
